cordic_iter: RTL

Iterative (one micro-rotation per clock) CORDIC rotator that rotates a signed (x, y) sample by a phase angle. Results are produced at full working width WW. It sits directly upstream of the `cordic_round` stage. Its `o_done` strobe drives that stage's `i_ce`, and its `o_xval`/`o_yval` drive that stage's `x_in`/`y_in`. Used in the NCO/mixer path where one rotation per several clocks is sufficient.

---
 rtl/cordic_pkg.sv | 48 ++++
 rtl/cordic_prerotate.sv | 55 +++++
 rtl/cordic_iter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC rotator.
// Gain compensation is compiled in when CORDIC_GAIN_COMP_EN is defined.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROT,
    ST_GAIN,
    ST_OUT
  } cordicState_e;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  // Approximates 1/K = 0.6074 as v/2 + v/8 - v/64 - v/512
  localparam int GAIN_SH_A = 1;
  localparam int GAIN_SH_B = 3;
  localparam int GAIN_SH_C = 6;
  localparam int GAIN_SH_D = 9;

  // 2^32 / (2*pi): converts a small angle in radians to 32-bit turn units
  localparam logic [63:0] ANGLE_SCALE32 = 64'd683565276;

  // atan(2^-k) as a fraction of a full turn, rounded to pw bits
  function automatic logic [31:0] atanEntry(input int k, input int pw);
    logic [63:0] a32;
    case (k)
      0:       a32 = 64'd536870912;
      1:       a32 = 64'd316933406;
      2:       a32 = 64'd167458907;
      3:       a32 = 64'd85004757;
      4:       a32 = 64'd42667331;
      5:       a32 = 64'd21354466;
      6:       a32 = 64'd10679838;
      7:       a32 = 64'd5340245;
      8:       a32 = 64'd2670163;
      9:       a32 = 64'd1335087;
      default: a32 = (ANGLE_SCALE32 + (64'd1 << (k - 1))) >> k;
    endcase
    if (pw >= 32) begin
      return a32[31:0];
    end
    return 32'((a32 + (64'd1 << (31 - pw))) >> (32 - pw));
  endfunction

endpackage

// File: rtl/cordic_prerotate.sv
// Input formatting plus quadrant pre-rotation: folds the phase into
// [-1/8, +1/8) turn and rotates the vector by the removed quarter turns.
module cordic_prerotate
  import cordic_pkg::*;
#(
  parameter int IW = 12,
  parameter int WW = 15,
  parameter int PW = 19
) (
  input  logic signed [IW-1:0] x_i,
  input  logic signed [IW-1:0] y_i,
  input  logic        [PW-1:0] phase_i,
  output logic signed [WW-1:0] x_o,
  output logic signed [WW-1:0] y_o,
  output logic signed [PW-1:0] z_o
);

  localparam int G = WW - IW - 2;
  localparam logic [PW-1:0] PHASE_EIGHTH = PW'(1) << (PW - 3);

  logic signed [WW-1:0] xFmt;
  logic signed [WW-1:0] yFmt;
  logic        [PW-1:0] phaseOff;
  logic        [1:0]    quad;

  assign xFmt     = {{(WW - IW){x_i[IW-1]}}, x_i} << G;
  assign yFmt     = {{(WW - IW){y_i[IW-1]}}, y_i} << G;
  assign phaseOff = phase_i + PHASE_EIGHTH;
  assign quad     = phaseOff[PW-1 -: 2];
  assign z_o      = phase_i - {quad, {(PW - 2){1'b0}}};

  always_comb begin
    x_o = xFmt;
    y_o = yFmt;
    case (quad)
      QUAD_1: begin
        x_o = -yFmt;
        y_o = xFmt;
      end
      QUAD_2: begin
        x_o = -xFmt;
        y_o = -yFmt;
      end
      QUAD_3: begin
        x_o = yFmt;
        y_o = -xFmt;
      end
      default: begin
        x_o = xFmt;
        y_o = yFmt;
      end
    endcase
  end

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC rotator, one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that removes the ~1.647 gain.
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int IW      = 12,
  parameter int WW      = 15,
  parameter int PW      = 19,
  parameter int NSTAGES = 13
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_stb,
  input  logic signed [IW-1:0] i_xval,
  input  logic signed [IW-1:0] i_yval,
  input  logic        [PW-1:0] i_phase,
  output logic                 o_busy,
  output logic                 o_done,
  output logic signed [WW-1:0] o_xval,
  output logic signed [WW-1:0] o_yval
);

  localparam int CW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTAGES - 1);

  cordicState_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [WW-1:0] x_q, x_d, y_q, y_d;
  logic signed [WW-1:0] xOut_q, xOut_d, yOut_q, yOut_d;
  logic signed [PW-1:0] z_q, z_d;
  logic signed [WW-1:0] xPre, yPre, xNext, yNext, xSh, ySh;
  logic signed [PW-1:0] zPre, zNext;
  logic [PW-1:0] angleTab [2**CW];
  logic accept;

  for (genvar k = 0; k < 2**CW; k++) begin : gAngle
    if (k < NSTAGES) begin : gUsed
      assign angleTab[k] = PW'(atanEntry(k, PW));
    end else begin : gPad
      assign angleTab[k] = '0;
    end
  end

  cordic_prerotate #(
    .IW(IW),
    .WW(WW),
    .PW(PW)
  ) uPrerotate (
    .x_i    (i_xval),
    .y_i    (i_yval),
    .phase_i(i_phase),
    .x_o    (xPre),
    .y_o    (yPre),
    .z_o    (zPre)
  );

`ifdef CORDIC_GAIN_COMP_EN
  function automatic logic signed [WW-1:0] gainComp(input logic signed [WW-1:0] v);
    return (v >>> GAIN_SH_A) + (v >>> GAIN_SH_B) - (v >>> GAIN_SH_C) - (v >>> GAIN_SH_D);
  endfunction
`endif

  // Rotate toward zero residual; both updates use the pre-update x and y
  always_comb begin
    xSh = x_q >>> cnt_q;
    ySh = y_q >>> cnt_q;
    if (!z_q[PW-1]) begin
      xNext = x_q - ySh;
      yNext = y_q + xSh;
      zNext = z_q - $signed(angleTab[cnt_q]);
    end else begin
      xNext = x_q + ySh;
      yNext = y_q - xSh;
      zNext = z_q + $signed(angleTab[cnt_q]);
    end
  end

  assign accept = i_stb && ((state_q == ST_IDLE) || (state_q == ST_OUT));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xOut_d  = xOut_q;
    yOut_d  = yOut_q;
    case (state_q)
      ST_IDLE, ST_OUT: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d = ST_ROT;
          cnt_d   = '0;
          x_d     = xPre;
          y_d     = yPre;
          z_d     = zPre;
        end
      end
      ST_ROT: begin
        x_d   = xNext;
        y_d   = yNext;
        z_d   = zNext;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d = '0;
`ifdef CORDIC_GAIN_COMP_EN
          state_d = ST_GAIN;
`else
          state_d = ST_OUT;
          xOut_d  = xNext;
          yOut_d  = yNext;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      ST_GAIN: begin
        xOut_d  = gainComp(x_q);
        yOut_d  = gainComp(y_q);
        state_d = ST_OUT;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      xOut_q  <= '0;
      yOut_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xOut_q  <= xOut_d;
      yOut_q  <= yOut_d;
    end
  end

  assign o_busy = (state_q == ST_ROT) || (state_q == ST_GAIN);
  assign o_done = (state_q == ST_OUT);
  assign o_xval = xOut_q;
  assign o_yval = yOut_q;

endmodule
